node_out_arb: RTL and testbench
===============================

// Module: node_out_arb
// PURPOSE
//   Output-port arbiter/scheduler for one MAZE node output (N/W/S/E link or local B port).
//   Shares the single output between NUM_REQ requesters: local A input plus the 4 neighbour inputs.
//   Two-class QoS round-robin with age-based promotion of starved qos=0 traffic.
//   One registered output stage gives 1-cycle latency at full throughput.
// PARAMETERS
//   NUM_REQ  5   number of requesters; index 0=A(local), 1=N, 2=W, 3=S, 4=E
//   AGE_MAX  15  lost-arbitration count at which a qos=0 requester is promoted to high class
// PORTS
//   clk       in   1              clock; all logic on rising edge
//   rst       in   1              synchronous, active-high reset
//   req_vld   in   NUM_REQ        per-requester packet valid
//   req_pkt   in   NUM_REQ*23     per-requester packet {type[1:0],qos,src[5:0],tgt[5:0],data[7:0]}; slot i at [23*i +: 23]
//   req_rdy   out  NUM_REQ        one-hot (or zero) accept; a transfer occurs when req_vld[i] & req_rdy[i]
//   out_vld   out  1              registered output packet valid
//   out_pkt   out  23             registered output packet, same field packing
//   out_rdy   in   1              downstream ready
//   grant_id  out  $clog2(NUM_REQ) index of the requester whose packet currently sits in out_pkt
// BEHAVIOUR
//   - Reset (rst=1 at posedge): out_vld=0, out_pkt=0, grant_id=0, rr_hi=rr_lo=0, all age counters=0.
//     Any packet held in the output stage is dropped. req_rdy=0 while rst=1.
//   - Interface: out_vld/out_pkt/grant_id are driven only from flops.
//     req_rdy is combinational from req_vld/req_pkt/state. Requesters must not make vld depend on rdy.
//   - Stage load: load = ~out_vld | out_rdy. No grant is issued when load=0.
//   - Class: hi[i] = req_vld[i] & (qos[i] | age[i]==AGE_MAX); lo[i] = req_vld[i] & ~hi[i].
//   - Pick: if |hi, search hi from rr_hi upward modulo NUM_REQ; else search lo from rr_lo upward.
//     The first set bit wins.
//   - Grant (load & any req_vld):
//       - req_rdy[g]=1 only for the winner g.
//       - Next edge: out_vld=1, out_pkt=req_pkt[g], grant_id=g.
//       - The winning class pointer becomes (g+1) mod NUM_REQ (NUM_REQ-1 wraps to 0). The other class pointer is unchanged.
//   - No request & load: out_vld<=0 at next edge. Pointers and ages are unchanged.
//   - Backpressure (out_vld & ~out_rdy): out_pkt and grant_id are held stable. req_rdy=0. Ages frozen.
//   - Age, updated only on grant cycles:
//       - age[g]<=0.
//       - For i!=g with req_vld[i] & qos[i]==0 & age[i]<AGE_MAX: age[i]++, saturating at AGE_MAX.
//       - qos=1 requesters never age.
//       - Dropping req_vld does not clear age.
//   - Simultaneous drain+grant: out_rdy=1 with out_vld=1 and a pending request loads the new packet the same edge.
//     Throughput is 1 packet/cycle, no bubble.
//   - Latency: accept at edge k -> out_vld visible after edge k. Packet fields pass through unmodified.
//   - Width: age counters are $clog2(AGE_MAX+1) bits. Pointer arithmetic is mod NUM_REQ, not a power-of-2 wrap.
// STRUCTURE
//   - Package node_arb_pkg:
//       - PKT_W=23 and field offsets (DATA_LSB=0, TGT_LSB=8, SRC_LSB=14, QOS_BIT=20, TYPE_LSB=21).
//       - typedef struct packed pkt_t {type, qos, src, tgt, data}.
//       - Port index constants P_A/P_N/P_W/P_S/P_E.
//   - Sub-module node_rr_pick: (req vector, start pointer) -> one-hot grant + index + any.
//     Instantiated twice (hi, lo).
//   - Top holds the output register, pointers and age counters.
// TESTING
//   1. rst=1 for 2 cycles with all req_vld=1 -> req_rdy=0, out_vld=0, grant_id=0. After rst=0 the first grant goes to req 0.
//   2. Only req 2 valid, pkt type=1 qos=0 src=6'h09 tgt=6'h1B data=8'hA5, out_rdy=1
//      -> req_rdy=5'b00100 that cycle; next cycle out_vld=1, out_pkt equal, grant_id=2.
//   3. All 5 valid, qos=0, continuous, out_rdy=1 -> grant_id sequence 0,1,2,3,4,0 on consecutive cycles, no bubbles.
//   4. AGE_MAX=4; req 1 qos=1 and req 0 qos=0 continuous
//      -> grants 1,1,1,1; 5th grant is 0 (promoted, rr_hi=2 wraps to 0); age[0] returns to 0, then 1 resumes.
//   5. out_vld=1 with out_rdy=0 for 3 cycles, all req valid -> out_pkt/grant_id stable, req_rdy=0, ages unchanged.
//      out_rdy=1 -> drain and new grant on the same edge.
//   6. rst=1 for one cycle while out_vld=1 holding data 8'h3C -> next cycle out_vld=0, out_pkt=0.
//      The held packet is never delivered; arbitration restarts from index 0.

Source files
------------

// File: rtl/node_arb_pkg.sv
// Shared types and constants for the MAZE node output arbiter.
// Packet layout: {type[1:0], qos, src[5:0], tgt[5:0], data[7:0]}.
package node_arb_pkg;

   localparam int PKT_W    = 23;
   localparam int DATA_LSB = 0;
   localparam int TGT_LSB  = 8;
   localparam int SRC_LSB  = 14;
   localparam int QOS_BIT  = 20;
   localparam int TYPE_LSB = 21;

   localparam int P_A = 0;
   localparam int P_N = 1;
   localparam int P_W = 2;
   localparam int P_S = 3;
   localparam int P_E = 4;

   typedef struct packed {
      logic [1:0] pkt_type;
      logic       qos;
      logic [5:0] src;
      logic [5:0] tgt;
      logic [7:0] data;
   } pkt_t;

   // Increment modulo n; n need not be a power of two.
   function automatic int wrap_inc(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/node_rr_pick.sv
// Round-robin picker: first set request at or after ptr, modulo N.
// Produces the one-hot grant, its index and an any-request flag.
module node_rr_pick #(
   parameter  int N = 5,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         any
);

   int j;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = W'(j);
         end
      end
   end

endmodule

// File: rtl/node_out_arb.sv
// Output-port arbiter for one MAZE node output: two-class QoS
// round-robin with age promotion and a single registered output stage.
module node_out_arb
   import node_arb_pkg::*;
#(
   parameter  int NUM_REQ = 5,
   parameter  int AGE_MAX = 15,
   localparam int GW      = $clog2(NUM_REQ),
   localparam int AW      = $clog2(AGE_MAX + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_vld,
   input  logic [NUM_REQ*PKT_W-1:0] req_pkt,
   output logic [NUM_REQ-1:0]       req_rdy,
   output logic                     out_vld,
   output logic [PKT_W-1:0]         out_pkt,
   input  logic                     out_rdy,
   output logic [GW-1:0]            grant_id
);

   pkt_t               slot [NUM_REQ];
   logic [AW-1:0]      age  [NUM_REQ];
   logic [NUM_REQ-1:0] qos;
   logic [NUM_REQ-1:0] hi;
   logic [NUM_REQ-1:0] lo;
   logic [GW-1:0]      rr_hi;
   logic [GW-1:0]      rr_lo;
   pkt_t               out_q;

   logic [NUM_REQ-1:0] hi_gnt;
   logic [NUM_REQ-1:0] lo_gnt;
   logic [GW-1:0]      hi_idx;
   logic [GW-1:0]      lo_idx;
   logic               hi_any;
   logic               lo_any;

   logic [NUM_REQ-1:0] gnt_oh;
   logic [GW-1:0]      g;
   logic [GW-1:0]      g_nxt;
   logic               load;
   logic               grant;

   // A qos=0 requester that has lost AGE_MAX times competes as high class.
   always_comb begin
      qos = '0;
      hi  = '0;
      lo  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         slot[i] = req_pkt[PKT_W*i +: PKT_W];
         qos[i]  = slot[i].qos;
         hi[i]   = req_vld[i] & (qos[i] | (age[i] == AW'(AGE_MAX)));
         lo[i]   = req_vld[i] & ~hi[i];
      end
   end

   node_rr_pick #(.N(NUM_REQ)) u_pick_hi (
      .req (hi),
      .ptr (rr_hi),
      .gnt (hi_gnt),
      .idx (hi_idx),
      .any (hi_any)
   );

   node_rr_pick #(.N(NUM_REQ)) u_pick_lo (
      .req (lo),
      .ptr (rr_lo),
      .gnt (lo_gnt),
      .idx (lo_idx),
      .any (lo_any)
   );

   assign gnt_oh = hi_any ? hi_gnt : lo_gnt;
   assign g      = hi_any ? hi_idx : lo_idx;
   assign g_nxt  = GW'(wrap_inc(int'(g), NUM_REQ));
   assign load   = ~out_vld | out_rdy;
   assign grant  = ~rst & load & (|req_vld);
   assign req_rdy = grant ? gnt_oh : '0;

   assign out_pkt = out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_q    <= '0;
         grant_id <= '0;
         rr_hi    <= '0;
         rr_lo    <= '0;
         for (int i = 0; i < NUM_REQ; i++) age[i] <= '0;
      end else if (grant) begin
         out_vld  <= 1'b1;
         out_q    <= slot[g];
         grant_id <= g;
         if (hi_any) rr_hi <= g_nxt;
         else        rr_lo <= g_nxt;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == g)
               age[i] <= '0;
            else if (req_vld[i] & ~qos[i] & (age[i] < AW'(AGE_MAX)))
               age[i] <= age[i] + 1'b1;
         end
      end else if (load) begin
         out_vld <= 1'b0;
      end
   end

endmodule

// File: tb/tb_node_out_arb.sv
// Randomized and directed bench for node_out_arb with a queue-free
// behavioural model of the two-class arbitration rules.
module tb_node_out_arb;
   import node_arb_pkg::*;

   localparam int N    = 5;
   localparam int AMAX = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_vld;
   logic [N*23-1:0]  req_pkt;
   logic [N-1:0]     req_rdy;
   logic             out_vld;
   logic [22:0]      out_pkt;
   logic             out_rdy;
   logic [2:0]       grant_id;

   always #5 clk = ~clk;

   node_out_arb #(.NUM_REQ(N), .AGE_MAX(AMAX)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_vld  (req_vld),
      .req_pkt  (req_pkt),
      .req_rdy  (req_rdy),
      .out_vld  (out_vld),
      .out_pkt  (out_pkt),
      .out_rdy  (out_rdy),
      .grant_id (grant_id)
   );

   int total = 0;
   int bad   = 0;

   bit          m_vld;
   logic [22:0] m_pkt;
   int          m_gid;
   int          m_rrh;
   int          m_rrl;
   int          m_age [N];
   logic [4:0]  got_rdy;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_vld = 0;
      m_pkt = '0;
      m_gid = 0;
      m_rrh = 0;
      m_rrl = 0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
   endtask

   function automatic int model_pick(input logic [4:0] v,
                                     input logic [N*23-1:0] p,
                                     output bit used_hi);
      bit is_hi [N];
      int start;
      int i;
      used_hi = 0;
      for (int k = 0; k < N; k++) begin
         is_hi[k] = v[k] && (p[23*k+20] || m_age[k] == AMAX);
         if (is_hi[k]) used_hi = 1;
      end
      start = used_hi ? m_rrh : m_rrl;
      for (int k = 0; k < N; k++) begin
         i = (start + k) % N;
         if (v[i] && (is_hi[i] == used_hi)) return i;
      end
      return -1;
   endfunction

   function automatic logic [N*23-1:0] gen(input int qmode);
      logic [N*23-1:0] r;
      logic [22:0]     x;
      r = '0;
      for (int i = 0; i < N; i++) begin
         x = 23'($urandom);
         if (qmode == 0) x[20] = 1'b0;
         else x[20] = ($urandom_range(0, 3) == 0);
         r[23*i +: 23] = x;
      end
      return r;
   endfunction

   task automatic step(input logic r, input logic [4:0] v,
                       input logic [N*23-1:0] p, input logic ordy);
      int g;
      bit uh;
      bit load;
      @(negedge clk);
      rst     = r;
      req_vld = v;
      req_pkt = p;
      out_rdy = ordy;
      #1;
      chk("out_vld", 32'(out_vld), 32'(m_vld));
      chk("out_pkt", 32'(out_pkt), 32'(m_pkt));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      load = !m_vld || ordy;
      g  = -1;
      uh = 0;
      if (!r && load && v != 0) g = model_pick(v, p, uh);
      chk("req_rdy", 32'(req_rdy), (g >= 0) ? (32'd1 << g) : 32'd0);
      got_rdy = req_rdy;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else if (g >= 0) begin
         for (int i = 0; i < N; i++) begin
            if (i == g) m_age[i] = 0;
            else if (v[i] && !p[23*i+20] && m_age[i] < AMAX) m_age[i]++;
         end
         m_vld = 1;
         m_pkt = p[23*g +: 23];
         m_gid = g;
         if (uh) m_rrh = (g + 1) % N;
         else    m_rrl = (g + 1) % N;
      end else if (load) begin
         m_vld = 0;
      end
      #1;
   endtask

   initial begin
      logic [N*23-1:0] p;
      logic [N*23-1:0] p5;
      logic [22:0]     pk;
      rst     = 1'b1;
      req_vld = '0;
      req_pkt = '0;
      out_rdy = 1'b1;
      model_reset();

      // reset with all requesters valid
      step(1, 5'h1f, gen(0), 1);
      step(1, 5'h1f, gen(0), 1);
      chk("rst_rdy", 32'(got_rdy), 32'd0);
      chk("rst_vld", 32'(out_vld), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      p = gen(0);
      step(0, 5'h1f, p, 1);
      chk("first_rdy", 32'(got_rdy), 32'd1);
      chk("first_gid", 32'(grant_id), 32'd0);
      chk("first_pkt", 32'(out_pkt), 32'(p[22:0]));

      // continuous all-valid low class
      for (int k = 0; k < 5; k++) begin
         step(0, 5'h1f, gen(0), 1);
         chk("rr_gid", 32'(grant_id), 32'((k + 1) % 5));
         chk("rr_vld", 32'(out_vld), 32'd1);
      end

      // single requester pass-through
      step(1, 5'h00, gen(0), 1);
      pk = {2'b01, 1'b0, 6'h09, 6'h1B, 8'hA5};
      p = gen(0);
      p[68:46] = pk;
      step(0, 5'b00100, p, 1);
      chk("one_rdy", 32'(got_rdy), 32'b00100);
      chk("one_vld", 32'(out_vld), 32'd1);
      chk("one_pkt", 32'(out_pkt), 32'h225BA5);
      chk("one_gid", 32'(grant_id), 32'd2);
      step(0, 5'b00000, gen(0), 1);
      chk("idle_vld", 32'(out_vld), 32'd0);

      // age promotion of a starved qos=0 requester
      step(1, 5'h00, gen(0), 1);
      for (int k = 0; k < AMAX + 2; k++) begin
         p = gen(0);
         p[43] = 1'b1;
         step(0, 5'b00011, p, 1);
         chk("age_rdy", 32'(got_rdy), (k == AMAX) ? 32'd1 : 32'd2);
      end

      // backpressure hold then drain+grant
      step(1, 5'h00, gen(0), 1);
      p5 = gen(0);
      step(0, 5'h1f, p5, 1);
      chk("bp_first", 32'(got_rdy), 32'd1);
      for (int k = 0; k < 3; k++) begin
         step(0, 5'h1f, gen(0), 0);
         chk("bp_rdy", 32'(got_rdy), 32'd0);
         chk("bp_pkt", 32'(out_pkt), 32'(p5[22:0]));
         chk("bp_gid", 32'(grant_id), 32'd0);
         chk("bp_vld", 32'(out_vld), 32'd1);
      end
      step(0, 5'h1f, gen(0), 1);
      chk("drain_rdy", 32'(got_rdy), 32'b00010);
      chk("drain_gid", 32'(grant_id), 32'd1);

      // reset drops a held packet
      p = gen(0);
      p[7:0] = 8'h3C;
      step(0, 5'b00001, p, 1);
      chk("hold_data", 32'(out_pkt[7:0]), 32'h3C);
      step(1, 5'h1f, gen(0), 0);
      chk("drop_vld", 32'(out_vld), 32'd0);
      chk("drop_pkt", 32'(out_pkt), 32'd0);
      step(0, 5'h1f, gen(0), 1);
      chk("restart_rdy", 32'(got_rdy), 32'd1);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         step(($urandom_range(0, 99) == 0), 5'($urandom), gen(2),
              ($urandom_range(0, 3) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
